// File: rtl/flash_stream_pkg.sv
// Shared types and widths for the flash stream reader and its output FIFO.
`timescale 1ns/1ps
package flash_stream_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REQ         = 2'd1,
        WAIT_ACK    = 2'd2,
        DRAIN_ABORT = 2'd3
    } fsm_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

    // Maps a 24-bit flash byte address onto the Wishbone address space.
    function automatic logic [31:0] flash_to_wb(input logic [31:0]       base,
                                                input logic [ADDR_W-1:0] addr);
        return base + {8'h0, addr};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO of {last, data} entries with synchronous flush.
`timescale 1ns/1ps
module byte_fifo
    import flash_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Flush overrides both push and pop; a push into a full FIFO needs a pop alongside.
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !flush && !empty;
        do_push = push && !flush && (!full || do_pop);
        head    = empty ? '0 : mem[rd_ptr];
    end

    // Storage array; written only at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flash_stream_reader.sv
// Wishbone master turning (address, length) commands into single-byte flash reads,
// delivering the bytes on a valid/ready stream through a small FWFT FIFO.
`timescale 1ns/1ps
module flash_stream_reader
    import flash_stream_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 4096,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic              busy,
    output logic              err,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [31:0]       wb_adr,
    output logic [31:0]       wb_dat_mosi,
    input  logic [31:0]       wb_dat_miso,
    input  logic              wb_ack,
    input  logic              wb_stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fsm_t              state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              cmd_accept;
    logic              bus_ack;
    logic              req_accept;
    logic              tmo_hit;
    logic              fifo_space;
    logic              fifo_push;
    fifo_entry_t       push_entry;
    fifo_entry_t       fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full_unused;
    logic              fifo_empty;
    logic              unused_miso;

    // Command handshake, bus qualifiers and the byte captured on ack.
    always_comb begin
        cmd_ready       = (state == IDLE) && !abort;
        cmd_accept      = cmd_valid && cmd_ready;
        // An ack only counts once the strobe has been taken down inside an open cycle.
        bus_ack         = wb_ack && wb_cyc && !wb_stb;
        req_accept      = wb_stb && !wb_stall;
        tmo_hit         = (tmo_cnt == TMO_W'(ACK_TIMEOUT));
        // No byte is in flight while in REQ, so the FIFO count alone decides space.
        fifo_space      = (fifo_count < CNT_W'(FIFO_DEPTH));
        fifo_push       = (state == WAIT_ACK) && bus_ack && !abort;
        push_entry.last = (remaining == LEN_W'(1));
        push_entry.data = wb_dat_miso[BYTE_W-1:0];
    end

    // Bus-facing and stream-facing outputs.
    always_comb begin
        busy        = (state != IDLE) || wb_cyc;
        wb_we       = 1'b0;
        wb_dat_mosi = 32'h0;
        wb_adr      = flash_to_wb(ADDR_BASE, cur_addr);
        out_valid   = !fifo_empty;
        out_data    = fifo_head.data;
        out_last    = fifo_head.last;
        unused_miso = ^wb_dat_miso[31:BYTE_W];
    end

    // Command sequencer: one outstanding single-byte read at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            tmo_cnt   <= '0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                        err       <= 1'b0;
                        if (cmd_len != '0) begin
                            state <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (abort) begin
                        wb_stb    <= 1'b0;
                        remaining <= '0;
                        if (req_accept) begin
                            // Slave took the request this very cycle: let it finish.
                            tmo_cnt <= TMO_W'(1);
                            state   <= DRAIN_ABORT;
                        end else begin
                            wb_cyc <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (wb_stb) begin
                        if (!wb_stall) begin
                            wb_stb  <= 1'b0;
                            tmo_cnt <= TMO_W'(1);
                            state   <= WAIT_ACK;
                        end
                    end else if (fifo_space) begin
                        wb_cyc <= 1'b1;
                        wb_stb <= 1'b1;
                    end
                end

                WAIT_ACK: begin
                    if (bus_ack) begin
                        wb_cyc <= 1'b0;
                        if (abort) begin
                            remaining <= '0;
                            state     <= IDLE;
                        end else begin
                            cur_addr  <= cur_addr + 1'b1;
                            remaining <= remaining - 1'b1;
                            state     <= (remaining == LEN_W'(1)) ? IDLE : REQ;
                        end
                    end else if (tmo_hit) begin
                        err       <= 1'b1;
                        wb_cyc    <= 1'b0;
                        remaining <= '0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (abort) begin
                            remaining <= '0;
                            state     <= DRAIN_ABORT;
                        end
                    end
                end

                DRAIN_ABORT: begin
                    // Hold the cycle open until the slave finishes; the byte is dropped.
                    if (bus_ack) begin
                        wb_cyc <= 1'b0;
                        state  <= IDLE;
                    end else if (tmo_hit) begin
                        err    <= 1'b1;
                        wb_cyc <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    wb_cyc <= 1'b0;
                    wb_stb <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (abort),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (out_ready),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full_unused),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_flash_stream_reader.sv
// Directed bench for flash_stream_reader with a behavioural Wishbone flash slave.
`timescale 1ns/1ps
module tb_flash_stream_reader;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        abort;
    logic        busy;
    logic        err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_mosi;
    logic [31:0] wb_dat_miso = 32'h0;
    logic        wb_ack = 1'b0;
    logic        wb_stall = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    // Slave controls (written by the stimulus) and slave state (written by the slave).
    int          slave_lat   = 1;
    bit          noack       = 1'b0;
    int          stall_total = 0;
    int          stall_cycles = 0;
    int          adr_chg     = 0;
    int          ack_cd      = 0;
    logic [31:0] stall_ref   = 32'h0;
    logic [7:0]  pend_data   = 8'h0;

    logic [31:0] acc_adr [$];
    logic [8:0]  strm [$];

    flash_stream_reader #(
        .FIFO_DEPTH  (8),
        .ACK_TIMEOUT (16),
        .ADDR_BASE   (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .abort       (abort),
        .busy        (busy),
        .err         (err),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_adr      (wb_adr),
        .wb_dat_mosi (wb_dat_mosi),
        .wb_dat_miso (wb_dat_miso),
        .wb_ack      (wb_ack),
        .wb_stall    (wb_stall),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    // Flash slave: stalls the first stall_total strobe cycles, acks slave_lat cycles after accept.
    // Returned byte is 0xA0 + low address byte; upper bits carry junk.
    always @(negedge clk) begin
        wb_ack = 1'b0;
        if (ack_cd > 0) begin
            ack_cd = ack_cd - 1;
            if (ack_cd == 0) begin
                wb_ack      = 1'b1;
                wb_dat_miso = {24'h5A5A5A, pend_data};
            end
        end
        if (rst_n && wb_cyc && wb_stb) begin
            if (stall_cycles < stall_total) begin
                if (stall_cycles == 0) stall_ref = wb_adr;
                else if (wb_adr !== stall_ref) adr_chg = adr_chg + 1;
                wb_stall     = 1'b1;
                stall_cycles = stall_cycles + 1;
            end else begin
                if (stall_cycles > 0 && acc_adr.size() == 0 && wb_adr !== stall_ref) begin
                    adr_chg = adr_chg + 1;
                end
                wb_stall  = 1'b0;
                acc_adr.push_back(wb_adr);
                pend_data = 8'hA0 + wb_adr[7:0];
                if (!noack) ack_cd = slave_lat;
            end
        end else begin
            wb_stall = 1'b0;
        end
    end

    // Stream sink: logs every byte popped.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) strm.push_back({out_last, out_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) step();
    endtask

    function automatic logic [31:0] aget(input int i);
        if (i < acc_adr.size()) return acc_adr[i];
        return 'x;
    endfunction

    function automatic logic [8:0] sget(input int i);
        if (i < strm.size()) return strm[i];
        return 'x;
    endfunction

    task automatic send_cmd(input logic [23:0] a, input logic [15:0] l);
        bit got = 1'b0;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                got = 1'b1;
                step();
                break;
            end
            step();
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            step();
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int a0;
        int s0;
        int n;
        logic [8:0] e9;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 24'h0;
        cmd_len   = 16'h0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_cyc",       32'(wb_cyc),    32'd0);
        check("rst_stb",       32'(wb_stb),    32'd0);
        check("rst_adr",       wb_adr,         BASE);
        check("rst_valid",     32'(out_valid), 32'd0);
        check("rst_data",      32'(out_data),  32'd0);
        check("rst_last",      32'(out_last),  32'd0);
        check("rst_we",        32'(wb_we),     32'd0);
        check("rst_mosi",      wb_dat_mosi,    32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_adr", wb_adr, BASE);

        // Basic 4-byte read
        out_ready = 1'b1;
        slave_lat = 2;
        a0 = acc_adr.size();
        s0 = strm.size();
        send_cmd(24'h050000, 16'd4);
        wait_idle("basic_idle", 300);
        settle();
        check("basic_nreads", 32'(acc_adr.size() - a0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("basic_adr", aget(a0 + i), 32'h4005_0000 + 32'(i));
            e9 = {(i == 3), 8'(8'hA0 + i)};
            check("basic_byte", 32'(sget(s0 + i)), 32'(e9));
        end
        check("basic_nbytes", 32'(strm.size() - s0), 32'd4);

        // 50 stall cycles on the first request
        stall_total = 50;
        a0 = acc_adr.size();
        s0 = strm.size();
        send_cmd(24'h000010, 16'd2);
        wait_idle("stall_idle", 400);
        settle();
        check("stall_cycles", 32'(stall_cycles), 32'd50);
        check("stall_adr_chg", 32'(adr_chg), 32'd0);
        check("stall_nreads", 32'(acc_adr.size() - a0), 32'd2);
        check("stall_adr0", aget(a0), 32'h4000_0010);
        check("stall_adr1", aget(a0 + 1), 32'h4000_0011);
        check("stall_b0", 32'(sget(s0)), 32'h0B0);
        check("stall_b1", 32'(sget(s0 + 1)), 32'h1B1);

        // Back-pressure: 20 bytes with a stalled consumer
        out_ready = 1'b0;
        a0 = acc_adr.size();
        s0 = strm.size();
        send_cmd(24'h000100, 16'd20);
        repeat (100) step();
        check("bp_nreads_full", 32'(acc_adr.size() - a0), 32'd8);
        check("bp_cyc_idle", 32'(wb_cyc), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'h0A0);
        out_ready = 1'b1;
        wait_idle("bp_idle", 600);
        settle();
        check("bp_nreads", 32'(acc_adr.size() - a0), 32'd20);
        check("bp_last_adr", aget(a0 + 19), 32'h4000_0113);
        check("bp_nbytes", 32'(strm.size() - s0), 32'd20);
        for (int i = 0; i < 20; i++) begin
            e9 = {(i == 19), 8'(8'hA0 + i)};
            check("bp_byte", 32'(sget(s0 + i)), 32'(e9));
        end

        // Address wrap at the top of the 24-bit space
        a0 = acc_adr.size();
        s0 = strm.size();
        send_cmd(24'hFFFFFE, 16'd3);
        wait_idle("wrap_idle", 300);
        settle();
        check("wrap_adr0", aget(a0),     32'h40FF_FFFE);
        check("wrap_adr1", aget(a0 + 1), 32'h40FF_FFFF);
        check("wrap_adr2", aget(a0 + 2), 32'h4000_0000);
        check("wrap_b0", 32'(sget(s0)),     32'h09E);
        check("wrap_b1", 32'(sget(s0 + 1)), 32'h09F);
        check("wrap_b2", 32'(sget(s0 + 2)), 32'h1A0);

        // Ack timeout
        noack = 1'b1;
        a0 = acc_adr.size();
        s0 = strm.size();
        send_cmd(24'h000200, 16'd2);
        for (int i = 0; i < 200; i++) begin
            if (acc_adr.size() != a0) break;
            step();
        end
        n = 0;
        while (wb_cyc && n < 100) begin
            step();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd16);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_ready", 32'(cmd_ready), 32'd1);
        settle();
        check("tmo_err_sticky", 32'(err), 32'd1);
        check("tmo_nreads", 32'(acc_adr.size() - a0), 32'd1);
        check("tmo_nbytes", 32'(strm.size() - s0), 32'd0);
        noack = 1'b0;
        a0 = acc_adr.size();
        s0 = strm.size();
        send_cmd(24'h000300, 16'd1);
        check("tmo_err_cleared", 32'(err), 32'd0);
        wait_idle("tmo_next_idle", 300);
        settle();
        check("tmo_next_byte", 32'(sget(s0)), 32'h1A0);

        // Abort together with an offered command: abort wins
        cmd_addr  = 24'h000600;
        cmd_len   = 16'd3;
        cmd_valid = 1'b1;
        abort     = 1'b1;
        #1;
        check("abort_blocks_ready", 32'(cmd_ready), 32'd0);
        step();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        step();
        check("abort_blocks_cmd", 32'(busy), 32'd0);

        // Abort while waiting for the ack of byte 2 of 5
        out_ready = 1'b0;
        slave_lat = 4;
        a0 = acc_adr.size();
        s0 = strm.size();
        send_cmd(24'h000400, 16'd5);
        for (int i = 0; i < 200; i++) begin
            if (acc_adr.size() - a0 == 2) break;
            step();
        end
        check("abort_pre_valid", 32'(out_valid), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_flushed", 32'(out_valid), 32'd0);
        check("abort_cyc_held", 32'(wb_cyc), 32'd1);
        wait_idle("abort_idle", 100);
        settle();
        check("abort_nreads", 32'(acc_adr.size() - a0), 32'd2);
        check("abort_fifo_empty", 32'(out_valid), 32'd0);
        check("abort_nbytes", 32'(strm.size() - s0), 32'd0);
        send_cmd(24'h000500, 16'd0);
        repeat (10) step();
        check("len0_nreads", 32'(acc_adr.size() - a0), 32'd2);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_cyc", 32'(wb_cyc), 32'd0);
        check("len0_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
